// File: rtl/toggle_sched_pkg.sv
// Shared types for the toggle pulse scheduler: FSM state encoding and default field widths.
package toggle_sched_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int GAP_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gap_down_counter.sv
// Loadable down counter for the inter-pulse gap; expire flags the last low cycle.
module gap_down_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_clear,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_expire
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    // A count of 1 means this is the final gap cycle; the FSM leaves GAP on this edge.
    assign o_expire = (r_count <= W'(1));
    assign o_count  = r_count;

endmodule

// File: rtl/toggle_pulse_scheduler.sv
// Emits cmd_count one-cycle T strobes separated by cmd_gap low cycles, with abort/busy/done.
// Handshake: a command transfers on a CLK edge where cmd_valid && cmd_ready; cmd_ready is high only in IDLE with abort low.
module toggle_pulse_scheduler
    import toggle_sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [GAP_W-1:0] cmd_gap,
    input  logic             abort,
    output logic             T,
    output logic             busy,
    output logic             done,
    output state_t           o_state
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [GAP_W-1:0] r_gap;
    logic             r_t;
    logic             r_busy;
    logic             r_done;

    logic             w_accept;
    logic [CNT_W-1:0] w_cnt_dec;
    logic             w_gap_load;
    logic             w_gap_dec;
    logic             w_gap_clear;
    logic             w_gap_expire;
    logic [GAP_W-1:0] w_gap_count;

    assign cmd_ready = (r_state == IDLE) && !abort;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_cnt_dec = r_cnt - 1'b1;

    gap_down_counter #(
        .W (GAP_W)
    ) u_gap_cnt (
        .i_clk      (CLK),
        .i_rstn     (RSTn),
        .i_clear    (w_gap_clear),
        .i_load     (w_gap_load),
        .i_load_val (r_gap),
        .i_dec      (w_gap_dec),
        .o_count    (w_gap_count),
        .o_expire   (w_gap_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_gap_load  = 1'b0;
        w_gap_dec   = 1'b0;
        w_gap_clear = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (cmd_count == '0) ? DONE : PULSE;
                end
            end
            PULSE: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_gap_clear = 1'b1;
                end else if (w_cnt_dec == '0) begin
                    w_state_nxt = DONE;
                end else if (r_gap == '0) begin
                    w_state_nxt = PULSE;
                end else begin
                    w_state_nxt = GAP;
                    w_gap_load  = 1'b1;
                end
            end
            GAP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_gap_clear = 1'b1;
                end else begin
                    w_gap_dec = 1'b1;
                    if (w_gap_expire) begin
                        w_state_nxt = PULSE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_gap_clear = abort;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gap   <= '0;
            r_t     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Outputs are registered copies of the next state so T never sees an input combinationally.
            r_t     <= (w_state_nxt == PULSE);
            r_busy  <= (w_state_nxt == PULSE) || (w_state_nxt == GAP);
            r_done  <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_cnt <= cmd_count;
                r_gap <= cmd_gap;
            end else if (abort && (r_state != IDLE)) begin
                r_cnt <= '0;
                r_gap <= '0;
            end else if ((r_state == PULSE) && (r_cnt != '0)) begin
                r_cnt <= w_cnt_dec;
            end
        end
    end

    assign T       = r_t;
    assign busy    = r_busy;
    assign done    = r_done;
    assign o_state = r_state;

endmodule
